memory_data_sized: RTL and testbench
====================================

Name: memory_data_sized

Overview:
- Parametrised next-generation MIPS data memory for the MEM stage.
- Adds byte/halfword access with sign/zero extension, registered reads with a valid strobe, misalignment detection and a self-initialising reset sequencer.
- Keeps the step-gated access and the independent debug read port used by the debug unit.

Parameters:
BITS_SIZE, 32, data/address width; must be 32 when DMEM_SUBWORD_EN is defined
SIZE_MEM_DATA, 16, depth in words; power of two, >= 2
(localparam) ADDR_BITS, clog2(SIZE_MEM_DATA), word-index width

Ports:
i_clk  input  1  clock, all logic on rising edge
i_reset  input  1  synchronous, active-low reset
i_step  input  1  pipeline step enable; gates MEM-stage accesses
i_alu_address  input  BITS_SIZE  byte address from ALU
i_data_register  input  BITS_SIZE  store data (rt)
i_flag_mem_read  input  1  load request
i_flag_mem_write  input  1  store request
i_mem_size  input  2  00 byte, 01 half, 10/11 word
i_mem_unsigned  input  1  1 = zero-extend sub-word loads (LBU/LHU)
i_debug_address  input  BITS_SIZE  debug word index
o_data_read  output  BITS_SIZE  load result
o_read_valid  output  1  one-cycle strobe, o_data_read updated
o_debug_data  output  BITS_SIZE  word at debug index
o_misaligned  output  1  one-cycle strobe, misaligned access rejected
o_init_busy  output  1  initialisation sequence running

Behaviour:
- Reset (i_reset=0 at edge): state INIT, init counter 0, o_data_read=0, o_read_valid=0, o_debug_data=0, o_misaligned=0, o_init_busy=1.
- FSM INIT: each cycle writes word[cnt]=cnt (zero-extended), cnt++. After writing word SIZE_MEM_DATA-1, goes to READY; o_init_busy is 0 from the following cycle. Total: SIZE_MEM_DATA cycles after reset release.
- All requests in INIT are ignored: no write, no valid, no misaligned.
- Reset asserted mid-INIT restarts the counter at 0. Reset in READY re-runs INIT.
- READY: access fires when (read|write) & i_step. Requests with i_step=0 are ignored.
- Word index = i_alu_address[ADDR_BITS+1:2]. Upper bits are ignored, so addresses wrap modulo depth.
- Misaligned cases:
  - half with addr[0]=1;
  - word with addr[1:0]!=0.
  - Result: no write; o_misaligned=1 for one cycle; a read also pulses o_read_valid with o_data_read=0.
- Store, little-endian:
  - byte writes lane addr[1:0] (bits 8*off+7:8*off) from i_data_register[7:0];
  - half writes lane addr[1] from [15:0];
  - other bytes are unchanged.
- Load latency is 1 cycle. On the edge after the request, o_data_read holds the selected lane, sign-extended (i_mem_unsigned=0) or zero-extended (=1), and o_read_valid=1 for one cycle.
- Without a load, o_data_read holds its last value and o_read_valid=0.
- Read and write in the same cycle: the write is performed and the read returns the pre-write contents.
- Debug port: o_debug_data = word[i_debug_address[ADDR_BITS-1:0]], registered, 1 cycle latency. Updates every cycle regardless of i_step or state; reflects the INIT contents in progress.

Optional Feature:
- DMEM_SUBWORD_EN defined: i_mem_size and i_mem_unsigned are honoured as above.
- Undefined: both inputs are ignored, every access is a word access, and misalignment is checked on addr[1:0]!=0 only. Sub-word lane/extension logic is not synthesised.

Test Plan:
- Release reset, monitor o_init_busy -> high exactly 16 cycles. Then debug reads of indices 0..15 return 0..15.
- Store word 0xDEADBEEF to addr 0x8 with step=1, then LW 0x8 -> next cycle o_data_read=0xDEADBEEF, o_read_valid=1 one cycle.
- SB 0x80 to addr 0x9, then LB 0x9 -> 0xFFFFFF80; LBU 0x9 -> 0x00000080; LW 0x8 -> 0xDEAD80EF.
- LH addr 0x3 -> o_misaligned=1, o_read_valid=1, o_data_read=0. SW 0xFFFFFFFF to addr 0x6 -> o_misaligned=1, word 1 unchanged (0x1).
- SW 0x12345678 to addr 0x40 (depth 16) -> lands in word 0. SW with i_step=0 -> no change.
- Assert reset at cycle 5 of INIT -> counter restarts, o_init_busy stays high 16 more cycles. A load during INIT -> no o_read_valid.

Source files
------------

// File: rtl/memory_data_sized.sv
// MEM-stage data memory: step-gated loads/stores, self-initialising reset sequence, debug read port.
// Sub-word (byte/half) accesses with sign/zero extension are built only when DMEM_SUBWORD_EN is defined.
module memory_data_sized #(
    parameter int unsigned BITS_SIZE     = 32,
    parameter int unsigned SIZE_MEM_DATA = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_step,
    input  logic [BITS_SIZE-1:0] i_alu_address,
    input  logic [BITS_SIZE-1:0] i_data_register,
    input  logic                 i_flag_mem_read,
    input  logic                 i_flag_mem_write,
    input  logic [1:0]           i_mem_size,
    input  logic                 i_mem_unsigned,
    input  logic [BITS_SIZE-1:0] i_debug_address,
    output logic [BITS_SIZE-1:0] o_data_read,
    output logic                 o_read_valid,
    output logic [BITS_SIZE-1:0] o_debug_data,
    output logic                 o_misaligned,
    output logic                 o_init_busy
);

    localparam int unsigned ADDR_BITS = $clog2(SIZE_MEM_DATA);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t               state, state_next;
    logic [ADDR_BITS-1:0] cnt, cnt_next;
    logic                 access_c;

    logic [BITS_SIZE-1:0] mem [SIZE_MEM_DATA];

    logic [ADDR_BITS-1:0] word_idx_c;
    logic [ADDR_BITS-1:0] dbg_idx_c;
    logic [1:0]           off_c;
    logic [BITS_SIZE-1:0] rd_word_c;
    logic [BITS_SIZE-1:0] load_c;
    logic [BITS_SIZE-1:0] wmask_c;
    logic [BITS_SIZE-1:0] wdata_c;
    logic                 misaligned_c;
    logic                 do_write_c;
    logic                 do_read_c;
    logic                 unused_c;

    assign word_idx_c = i_alu_address[ADDR_BITS+1:2];
    assign dbg_idx_c  = i_debug_address[ADDR_BITS-1:0];
    assign off_c      = i_alu_address[1:0];
    assign rd_word_c  = mem[word_idx_c];

`ifdef DMEM_SUBWORD_EN
    logic [7:0]  lane_b_c;
    logic [15:0] lane_h_c;

    assign unused_c = ^{i_alu_address[BITS_SIZE-1:ADDR_BITS+2], i_debug_address[BITS_SIZE-1:ADDR_BITS]};

    // Lane selection, extension and store byte mask (little-endian)
    always_comb begin
        lane_b_c     = rd_word_c[{off_c, 3'b000} +: 8];
        lane_h_c     = off_c[1] ? rd_word_c[31:16] : rd_word_c[15:0];
        load_c       = rd_word_c;
        wmask_c      = '1;
        wdata_c      = i_data_register;
        misaligned_c = (off_c != 2'b00);
        case (i_mem_size)
            2'b00: begin
                load_c       = i_mem_unsigned ? {24'b0, lane_b_c} : {{24{lane_b_c[7]}}, lane_b_c};
                wmask_c      = BITS_SIZE'(32'h0000_00FF) << {off_c, 3'b000};
                wdata_c      = {4{i_data_register[7:0]}};
                misaligned_c = 1'b0;
            end
            2'b01: begin
                load_c       = i_mem_unsigned ? {16'b0, lane_h_c} : {{16{lane_h_c[15]}}, lane_h_c};
                wmask_c      = off_c[1] ? BITS_SIZE'(32'hFFFF_0000) : BITS_SIZE'(32'h0000_FFFF);
                wdata_c      = {2{i_data_register[15:0]}};
                misaligned_c = off_c[0];
            end
            default: ;
        endcase
    end
`else
    assign unused_c = ^{i_alu_address[BITS_SIZE-1:ADDR_BITS+2], i_debug_address[BITS_SIZE-1:ADDR_BITS],
                        i_mem_size, i_mem_unsigned};
    assign load_c       = rd_word_c;
    assign wmask_c      = '1;
    assign wdata_c      = i_data_register;
    assign misaligned_c = (off_c != 2'b00);
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state: INIT walks every word once, READY accepts stepped accesses
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        access_c   = 1'b0;
        case (state)
            ST_INIT: begin
                cnt_next = cnt + ADDR_BITS'(1);
                if (cnt == ADDR_BITS'(SIZE_MEM_DATA - 1)) state_next = ST_READY;
            end
            ST_READY: access_c = (i_flag_mem_read | i_flag_mem_write) & i_step;
            default:  state_next = ST_INIT;
        endcase
    end

    assign do_write_c = access_c & i_flag_mem_write & ~misaligned_c;
    assign do_read_c  = access_c & i_flag_mem_read;

    // Storage: INIT fill or masked store; reads above see pre-write contents
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            if (state == ST_INIT) begin
                mem[cnt] <= BITS_SIZE'(cnt);
            end else if (do_write_c) begin
                mem[word_idx_c] <= (rd_word_c & ~wmask_c) | (wdata_c & wmask_c);
            end
        end
    end

    // Registered outputs
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_data_read  <= '0;
            o_read_valid <= 1'b0;
            o_debug_data <= '0;
            o_misaligned <= 1'b0;
            o_init_busy  <= 1'b1;
        end else begin
            o_read_valid <= do_read_c;
            o_misaligned <= access_c & misaligned_c;
            if (do_read_c) o_data_read <= misaligned_c ? '0 : load_c;
            o_debug_data <= mem[dbg_idx_c];
            o_init_busy  <= (state_next == ST_INIT);
        end
    end

endmodule

// File: tb/tb_memory_data_sized.sv
// Randomised bench for memory_data_sized against a byte-array memory model.
module tb_memory_data_sized;

    localparam int unsigned BITS_SIZE     = 32;
    localparam int unsigned SIZE_MEM_DATA = 16;
    localparam int unsigned NBYTES        = 4 * SIZE_MEM_DATA;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        step;
    logic [31:0] alu_address;
    logic [31:0] data_register;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] debug_address;
    logic [31:0] data_read;
    logic        read_valid;
    logic [31:0] debug_data;
    logic        misaligned;
    logic        init_busy;

    memory_data_sized #(.BITS_SIZE(BITS_SIZE), .SIZE_MEM_DATA(SIZE_MEM_DATA)) dut (
        .i_clk           (clk),
        .i_reset         (rst_n),
        .i_step          (step),
        .i_alu_address   (alu_address),
        .i_data_register (data_register),
        .i_flag_mem_read (mem_read),
        .i_flag_mem_write(mem_write),
        .i_mem_size      (mem_size),
        .i_mem_unsigned  (mem_unsigned),
        .i_debug_address (debug_address),
        .o_data_read     (data_read),
        .o_read_valid    (read_valid),
        .o_debug_data    (debug_data),
        .o_misaligned    (misaligned),
        .o_init_busy     (init_busy)
    );

    always #5 clk = ~clk;

    logic [7:0]  mb [NBYTES];
    logic [31:0] last_data;
    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input int i);
        return {mb[4*i+3], mb[4*i+2], mb[4*i+1], mb[4*i]};
    endfunction

    task automatic model_init();
        for (int i = 0; i < int'(SIZE_MEM_DATA); i++)
            for (int k = 0; k < 4; k++)
                mb[4*i+k] = (k == 0) ? 8'(i) : 8'h00;
        last_data = 32'h0;
    endtask

    task automatic idle_inputs();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        step      = 1'b0;
    endtask

    // Called at a negedge; holds reset then counts o_init_busy cycles after release
    task automatic reset_and_count(input int abort_after, input string tag);
        int  n;
        logic saw;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        if (abort_after > 0) begin
            repeat (abort_after) @(posedge clk);
            @(negedge clk);
            rst_n = 1'b0;
            @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
        end
        model_init();
        // Requests during INIT must be ignored
        mem_read = 1'b1; mem_write = 1'b1; step = 1'b1;
        alu_address = 32'h4; data_register = 32'hFFFF_FFFF; mem_size = 2'b10;
        n = 0;
        saw = 1'b0;
        while (init_busy && n < 100) begin
            n++;
            if (read_valid || misaligned) saw = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        if (read_valid || misaligned) saw = 1'b1;
        idle_inputs();
        check({tag, ".busy_len"}, 32'(n), 32'd16);
        check({tag, ".no_strobe"}, 32'(saw), 32'd0);
    endtask

    task automatic do_op(input logic rd, input logic wr, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] data, input logic stp,
                         input string tag);
        int          es, nb, a;
        logic        mis, fire, ev;
        logic [31:0] v;
`ifdef DMEM_SUBWORD_EN
        es = (size == 2'b11) ? 2 : int'(size);
`else
        es = 2;
`endif
        nb   = (es == 0) ? 1 : ((es == 1) ? 2 : 4);
        a    = int'(addr % NBYTES);
        mis  = (a % nb) != 0;
        fire = (rd | wr) & stp;
        ev   = fire & rd;
        if (ev) begin
            v = 32'h0;
            if (!mis) begin
                for (int k = 0; k < nb; k++) v[8*k +: 8] = mb[a+k];
                if (nb < 4 && !uns && v[8*nb-1])
                    for (int k = nb; k < 4; k++) v[8*k +: 8] = 8'hFF;
            end
            last_data = v;
        end
        if (fire && wr && !mis)
            for (int k = 0; k < nb; k++) mb[a+k] = data[8*k +: 8];
        mem_read = rd; mem_write = wr; mem_size = size; mem_unsigned = uns;
        alu_address = addr; data_register = data; step = stp;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        check({tag, ".valid"}, 32'(read_valid), 32'(ev));
        check({tag, ".misaligned"}, 32'(misaligned), 32'(fire & mis));
        check({tag, ".data"}, data_read, last_data);
    endtask

    task automatic debug_dump(input string tag);
        for (int i = 0; i < int'(SIZE_MEM_DATA); i++) begin
            debug_address = ($urandom() & 32'hFFFF_FFF0) | 32'(i);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s.dbg%0d", tag, i), debug_data, model_word(i));
        end
    endtask

    initial begin
        rst_n = 1'b0; idle_inputs();
        alu_address = '0; data_register = '0; mem_size = 2'b10; mem_unsigned = 1'b0;
        debug_address = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.busy", 32'(init_busy), 32'd1);
        check("rst.valid", 32'(read_valid), 32'd0);
        check("rst.data", data_read, 32'h0);
        check("rst.mis", 32'(misaligned), 32'd0);
        check("rst.dbg", debug_data, 32'h0);

        reset_and_count(5, "midinit");
        debug_dump("init");

        do_op(0, 1, 2'b10, 0, 32'h8,  32'hDEAD_BEEF, 1, "sw8");
        do_op(1, 0, 2'b10, 0, 32'h8,  32'h0,         1, "lw8");
        do_op(0, 0, 2'b10, 0, 32'h0,  32'h0,         1, "idle");
        do_op(0, 1, 2'b00, 0, 32'h9,  32'h0000_0080, 1, "sb9");
        do_op(1, 0, 2'b00, 0, 32'h9,  32'h0,         1, "lb9");
        do_op(1, 0, 2'b00, 1, 32'h9,  32'h0,         1, "lbu9");
        do_op(1, 0, 2'b10, 0, 32'h8,  32'h0,         1, "lw8b");
        do_op(1, 0, 2'b01, 0, 32'h3,  32'h0,         1, "lh3");
        do_op(0, 1, 2'b10, 0, 32'h6,  32'hFFFF_FFFF, 1, "sw6");
        do_op(1, 0, 2'b10, 0, 32'h4,  32'h0,         1, "lw4");
        do_op(0, 1, 2'b10, 0, 32'h40, 32'h1234_5678, 1, "sw40");
        do_op(1, 0, 2'b10, 0, 32'h0,  32'h0,         1, "lw0");
        do_op(0, 1, 2'b10, 0, 32'h0,  32'h0,         0, "sw_nostep");
        do_op(1, 0, 2'b10, 0, 32'h0,  32'h0,         1, "lw0b");
        do_op(1, 1, 2'b10, 0, 32'hC,  32'hCAFE_F00D, 1, "rw_same");
        do_op(1, 0, 2'b10, 0, 32'hC,  32'h0,         1, "lwC");
        do_op(1, 0, 2'b01, 0, 32'h2,  32'h0,         1, "lh2");

        for (int i = 0; i < 300; i++) begin
            logic rd, wr, stp;
            logic [31:0] r;
            r   = $urandom();
            rd  = r[0];
            wr  = r[1];
            stp = (r[4:2] != 3'b000);
            do_op(rd, wr, r[6:5], r[7], $urandom_range(0, 255), $urandom(), stp,
                  $sformatf("rnd%0d", i));
        end
        debug_dump("final");

        reset_and_count(0, "ready_rst");
        debug_dump("reinit");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
